// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with a small TX FIFO in front of it. Software pushes words
//   through a valid/ready handshake. The FSM pops the FIFO head and serialises it
//   as START, DATA (LSB first), optional PARITY, then STOP. Queued words follow
//   each other with no idle gap between frames.
//
//   Optional feature: define UART_TX_PARITY_EN to compile in parity generation.
//   Without it, cfg_parity is ignored and frames carry no parity bit.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9)
//   FIFO_DEPTH  FIFO entries, power of two >= 2
//   BAUD_W      width of baud_div
//
// Ports
//   clk         system clock, posedge
//   rst         asynchronous active-high reset
//   baud_div    clocks per bit (0 behaves as 1)
//   cfg_stop2   0: one stop bit, 1: two stop bits
//   cfg_parity  00 none, 01 even, 10 odd, 11 none
//   tx_valid    write request
//   tx_data     word to queue
//   tx_ready    FIFO not full
//   tx          serial output, idle high (registered)
//   tx_busy     frame in progress (registered)
//   tx_done     one-cycle pulse per completed frame (registered)
//   fifo_level  number of queued words
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BAUD_W-1:0]             baud_div,
  input  logic                          cfg_stop2,
  input  logic [1:0]                    cfg_parity,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [3:0]      LAST_BIT  = 4'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count;
  logic                 push, pop, full, empty;

  assign full       = (count == DEPTH_CNT);
  assign empty      = (count == '0);
  assign tx_ready   = !full;
  assign fifo_level = count;
  assign push       = tx_valid && !full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Transmitter state
  state_t               state, state_next;
  logic [BAUD_W-1:0]    cnt, cnt_next;
  logic [BAUD_W-1:0]    n_reg, n_next;
  logic [3:0]           bit_idx, bit_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 stop2_reg, stop2_next;
  logic                 tx_next, busy_next, done_next;
  logic                 load_frame, bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_en, par_en_next, par_bit, par_bit_next;
`else
  logic unused_cfg_parity;
  assign unused_cfg_parity = ^cfg_parity;
`endif

  assign bit_end = (cnt == n_reg - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      n_reg     <= BAUD_W'(1);
      bit_idx   <= '0;
      shift     <= '0;
      stop2_reg <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      n_reg     <= n_next;
      bit_idx   <= bit_next;
      shift     <= shift_next;
      stop2_reg <= stop2_next;
      tx        <= tx_next;
      tx_busy   <= busy_next;
      tx_done   <= done_next;
`ifdef UART_TX_PARITY_EN
      par_en    <= par_en_next;
      par_bit   <= par_bit_next;
`endif
    end
  end

  // Next-state logic. tx/tx_busy/tx_done are computed here one cycle early
  // and registered, so the line changes exactly on the bit boundary.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    n_next     = n_reg;
    bit_next   = bit_idx;
    shift_next = shift;
    stop2_next = stop2_reg;
    tx_next    = tx;
    busy_next  = tx_busy;
    done_next  = 1'b0;
    load_frame = 1'b0;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_next  = par_en;
    par_bit_next = par_bit;
`endif

    case (state)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (!empty) load_frame = 1'b1;
      end
      START: begin
        if (bit_end) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = DATA;
          tx_next    = shift[0];
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (bit_idx == LAST_BIT) begin
            bit_next = '0;
`ifdef UART_TX_PARITY_EN
            if (par_en) begin
              state_next = PARITY;
              tx_next    = par_bit;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_next   = bit_idx + 1'b1;
            shift_next = shift >> 1;
            tx_next    = shift[1];
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = STOP;
          tx_next    = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_next = '0;
          if (stop2_reg && bit_idx == '0) begin
            bit_next = 4'd1;
          end else begin
            done_next = 1'b1;
            if (!empty) begin
              load_frame = 1'b1;
            end else begin
              state_next = IDLE;
              tx_next    = 1'b1;
              busy_next  = 1'b0;
            end
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase

    // Popping the head also latches the per-frame configuration
    if (load_frame) begin
      pop        = 1'b1;
      state_next = START;
      tx_next    = 1'b0;
      busy_next  = 1'b1;
      cnt_next   = '0;
      bit_next   = '0;
      shift_next = mem[rd_ptr];
      n_next     = (baud_div == '0) ? BAUD_W'(1) : baud_div;
      stop2_next = cfg_stop2;
`ifdef UART_TX_PARITY_EN
      par_en_next  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_bit_next = (^mem[rd_ptr]) ^ (cfg_parity == 2'b10);
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo. Words are queued as expected results
//   when pushed; a line monitor decodes each frame from tx, checks its shape
//   and bit timing, and compares the decoded word against the queue head.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int BW    = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [BW-1:0]             baud_div;
  logic                      cfg_stop2;
  logic [1:0]                cfg_parity;
  logic                      tx_valid;
  logic [DB-1:0]             tx_data;
  logic                      tx_ready, tx, tx_busy, tx_done;
  logic [$clog2(DEPTH):0]    fifo_level;

  int            total = 0;
  int            bad   = 0;
  logic [DB-1:0] exp_q[$];
  int            cur_n   = 1;
  int            cur_s   = 1;
  int            cur_par = 0;
  bit            mon_en  = 1'b0;
  int            cyc = 0;
  int            done_count = 0;
  int            done_cycles[$];
  int            exp_frames = 0;

  uart_tx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .BAUD_W(BW)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .cfg_stop2(cfg_stop2),
    .cfg_parity(cfg_parity), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst === 1'b0 && tx_done === 1'b1) begin
      done_count++;
      done_cycles.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DB-1:0] w);
    int t = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = w;
    while (tx_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      checkOutput("push_ready", tx_ready, 1);
      tx_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(w);
      exp_frames++;
      #1 tx_valid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    int t = 0;
    while ((exp_q.size() != 0 || tx_busy !== 1'b0 || fifo_level !== '0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("idle_reached", (t < 5000), 1);
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: detects a start bit on the falling sample and walks the frame
  initial begin : monitor
    logic [DB-1:0] word;
    logic [DB-1:0] want;
    logic          pbit;
    int            errs, n, s, p;
    word = '0;
    pbit = 1'b0;
    forever begin
      @(negedge clk);
      while (mon_en && rst === 1'b0 && tx === 1'b0) begin
        n = cur_n; s = cur_s; p = cur_par; errs = 0;
        if (tx_busy !== 1'b1) errs++;
        for (int c = 1; c < n; c++) begin
          @(negedge clk);
          if (tx !== 1'b0 || tx_busy !== 1'b1 || tx_done !== 1'b0) errs++;
        end
        for (int i = 0; i < DB; i++) begin
          for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c == 0) word[i] = tx;
            else if (tx !== word[i]) errs++;
            if (tx_busy !== 1'b1 || tx_done !== 1'b0) errs++;
          end
        end
        if (p != 0) begin
          for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c == 0) pbit = tx;
            else if (tx !== pbit) errs++;
            if (tx_busy !== 1'b1 || tx_done !== 1'b0) errs++;
          end
        end
        for (int c = 0; c < s * n; c++) begin
          @(negedge clk);
          if (tx !== 1'b1 || tx_busy !== 1'b1 || tx_done !== 1'b0) errs++;
        end
        @(negedge clk);
        checkOutput("done_pulse", tx_done, 1);
        checkOutput("frame_shape", errs, 0);
        if (exp_q.size() == 0) begin
          checkOutput("sb_size", exp_q.size(), 1);
        end else begin
          want = exp_q.pop_front();
          checkOutput("data", word, want);
          if (p != 0) checkOutput("parity", pbit, (p == 2) ? ~^want : ^want);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int base;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
    baud_div = 4; cfg_stop2 = 1'b0; cfg_parity = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_busy", tx_busy, 0);
    checkOutput("rst_done", tx_done, 0);
    checkOutput("rst_ready", tx_ready, 1);
    checkOutput("rst_level", fifo_level, 0);
    @(negedge clk) rst = 1'b0;
    mon_en = 1'b1;

    // 8N1, four clocks per bit
    cur_n = 4; baud_div = 4;
    applyStimulus(8'hA5);
    checkOutput("level_after_push", fifo_level, 1);
    @(negedge clk);
    checkOutput("tx_before_pop", tx, 1);
    @(negedge clk);
    checkOutput("tx_start_low", tx, 0);
    checkOutput("level_after_pop", fifo_level, 0);
    checkOutput("busy_start", tx_busy, 1);
    waitIdle();

    // baud_div of zero behaves as one clock per bit
    cur_n = 1; baud_div = 0;
    base = done_cycles.size();
    applyStimulus(8'h3C);
    applyStimulus(8'hC3);
    waitIdle();
    checkOutput("div0_frames", done_cycles.size() - base, 2);
    if (done_cycles.size() - base == 2)
      checkOutput("div0_len", done_cycles[base+1] - done_cycles[base], 10);

    // Three queued words go out back-to-back
    cur_n = 2; baud_div = 2;
    base = done_cycles.size();
    applyStimulus(8'h11);
    applyStimulus(8'h82);
    applyStimulus(8'h7E);
    waitIdle();
    checkOutput("b2b_frames", done_cycles.size() - base, 3);
    if (done_cycles.size() - base == 3) begin
      checkOutput("b2b_gap1", done_cycles[base+1] - done_cycles[base], 20);
      checkOutput("b2b_gap2", done_cycles[base+2] - done_cycles[base+1], 20);
    end

    // Fill the FIFO during a frame, try to overflow, then push a fifth word
    applyStimulus(8'h01);
    applyStimulus(8'h23);
    applyStimulus(8'h45);
    applyStimulus(8'h67);
    applyStimulus(8'h89);
    checkOutput("full_level", fifo_level, 4);
    checkOutput("full_ready", tx_ready, 0);
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1 tx_valid = 1'b0;
    checkOutput("full_level_hold", fifo_level, 4);
    applyStimulus(8'hAB);
    checkOutput("refill_level", fifo_level, 4);
    waitIdle();

    // Two stop bits, three clocks per bit
    cur_n = 3; cur_s = 2; baud_div = 3; cfg_stop2 = 1'b1;
    base = done_cycles.size();
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    waitIdle();
    checkOutput("stop2_frames", done_cycles.size() - base, 2);
    if (done_cycles.size() - base == 2)
      checkOutput("stop2_len", done_cycles[base+1] - done_cycles[base], 33);
    cur_s = 1; cfg_stop2 = 1'b0;

`ifdef UART_TX_PARITY_EN
    // Even then odd parity on the same word
    cur_n = 2; baud_div = 2; cfg_parity = 2'b01; cur_par = 1;
    base = done_cycles.size();
    applyStimulus(8'hA5);
    applyStimulus(8'hA5);
    waitIdle();
    if (done_cycles.size() - base == 2)
      checkOutput("parity_len", done_cycles[base+1] - done_cycles[base], 22);
    cfg_parity = 2'b10; cur_par = 2;
    applyStimulus(8'hA5);
    waitIdle();
    cfg_parity = 2'b00; cur_par = 0;
`endif

    // Reset in the middle of the data bits
    mon_en = 1'b0;
    cur_n = 4; baud_div = 4;
    applyStimulus(8'h0F);
    applyStimulus(8'h33);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("pre_rst_busy", tx_busy, 1);
    checkOutput("pre_rst_level", fifo_level, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_tx", tx, 1);
    checkOutput("mid_rst_busy", tx_busy, 0);
    checkOutput("mid_rst_level", fifo_level, 0);
    checkOutput("mid_rst_ready", tx_ready, 1);
    base = done_count;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    exp_q.delete();
    exp_frames -= 2;
    repeat (60) @(negedge clk);
    checkOutput("no_done_after_rst", done_count - base, 0);
    checkOutput("idle_after_rst", tx, 1);
    mon_en = 1'b1;
    applyStimulus(8'h5A);
    waitIdle();

    checkOutput("done_total", done_count, exp_frames);
    checkOutput("sb_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
